// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - request/response and memory-side bus for mem_access_sequencer
interface mem_access_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [31:0]           req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  rsp_err_o;
    logic                  Write_Enable_o;
    logic [31:0]           Address_o;
    logic [DATA_WIDTH-1:0] Write_Data_o;
    logic [DATA_WIDTH-1:0] Read_Data_i;
    logic [CNT_WIDTH-1:0]  txn_count_o;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i, Read_Data_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               Write_Enable_o, Address_o, Write_Data_o, txn_count_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i, Read_Data_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               Write_Enable_o, Address_o, Write_Data_o, txn_count_o
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - one-outstanding load/store sequencer for the ROM/RAM system
// Optional macro MISALIGN_CHECK_EN rejects accesses whose addr[1:0] is non-zero.
module mem_access_sequencer #(
    parameter int          MEMORY_DEPTH = 64,
    parameter int          DATA_WIDTH   = 32,
    parameter logic [31:0] ROM_BASE     = 32'h0040_0000,
    parameter logic [31:0] RAM_BASE     = 32'h1001_0000,
    parameter int          CNT_WIDTH    = 16
) (
    input  logic        CLK,
    input  logic        rst_n,
    mem_access_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    // 33-bit window bounds so base + window can never wrap past 2^32
    localparam logic [32:0] WIN    = 33'(4 * MEMORY_DEPTH);
    localparam logic [32:0] ROM_LO = {1'b0, ROM_BASE};
    localparam logic [32:0] ROM_HI = ROM_LO + WIN;
    localparam logic [32:0] RAM_LO = {1'b0, RAM_BASE};
    localparam logic [32:0] RAM_HI = RAM_LO + WIN;

    state_t                state_q, state_d;
    logic                  we_q, err_q;
    logic [31:0]           addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic                  rsp_err_q;
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic [32:0] addr_ext;
    logic        rom_hit, ram_hit, misalign, req_err;
    logic        accept, rsp_fire;
    logic        ready_c, valid_c, we_c;

    assign addr_ext = {1'b0, bus.req_addr_i};
    assign rom_hit  = (addr_ext >= ROM_LO) && (addr_ext < ROM_HI);
    assign ram_hit  = (addr_ext >= RAM_LO) && (addr_ext < RAM_HI);

`ifdef MISALIGN_CHECK_EN
    assign misalign = |bus.req_addr_i[1:0];
`else
    assign misalign = 1'b0;
`endif

    assign req_err = !(rom_hit || ram_hit) || (bus.req_we_i && rom_hit) || misalign;

    always_comb begin
        state_d  = state_q;
        ready_c  = 1'b0;
        valid_c  = 1'b0;
        we_c     = 1'b0;
        accept   = 1'b0;
        rsp_fire = 1'b0;
        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.req_valid_i) begin
                    accept  = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                we_c    = we_q && !err_q;
                state_d = RESP;
            end
            RESP: begin
                valid_c = 1'b1;
                if (bus.rsp_ready_i) begin
                    rsp_fire = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            rsp_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= bus.req_we_i;
                err_q   <= req_err;
                addr_q  <= bus.req_addr_i;
                wdata_q <= bus.req_wdata_i;
            end
            // Read data is captured at the end of the single access cycle and held through RESP
            if (state_q == ACCESS) begin
                rdata_q   <= (we_q || err_q) ? '0 : bus.Read_Data_i;
                rsp_err_q <= err_q;
            end
            if (rsp_fire)
                cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign bus.req_ready_o    = ready_c;
    assign bus.rsp_valid_o    = valid_c;
    assign bus.Write_Enable_o = we_c;
    assign bus.Address_o      = addr_q;
    assign bus.Write_Data_o   = wdata_q;
    assign bus.rsp_rdata_o    = rdata_q;
    assign bus.rsp_err_o      = rsp_err_q;
    assign bus.txn_count_o    = cnt_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb/tb_mem_access_sequencer.sv - scoreboard bench for mem_access_sequencer with ROM/RAM model
module tb_mem_access_sequencer;

    localparam logic [31:0] ROM_BASE = 32'h0040_0000;
    localparam logic [31:0] RAM_BASE = 32'h1001_0000;

    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    always #5 CLK = ~CLK;

    mem_access_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) bus ();

    mem_access_sequencer #(
        .MEMORY_DEPTH(64), .DATA_WIDTH(32), .ROM_BASE(ROM_BASE),
        .RAM_BASE(RAM_BASE), .CNT_WIDTH(16)
    ) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [31:0] ram [64];
    logic [31:0] rom [64];
    logic [31:0] ram_off, rom_off;

    assign ram_off = bus.Address_o - RAM_BASE;
    assign rom_off = bus.Address_o - ROM_BASE;

    always_comb begin
        bus.Read_Data_i = 32'h0;
        if (bus.Address_o >= RAM_BASE && bus.Address_o < RAM_BASE + 32'd256)
            bus.Read_Data_i = ram[ram_off[7:2]];
        else if (bus.Address_o >= ROM_BASE && bus.Address_o < ROM_BASE + 32'd256)
            bus.Read_Data_i = rom[rom_off[7:2]];
    end

    always @(posedge CLK)
        if (bus.Write_Enable_o && bus.Address_o >= RAM_BASE && bus.Address_o < RAM_BASE + 32'd256)
            ram[ram_off[7:2]] <= bus.Write_Data_o;

    int passed = 0;
    int total  = 0;
    int we_cycles = 0;
    logic [32:0] sb [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge CLK) begin
        if (bus.Write_Enable_o) we_cycles++;
        if (rst_n && bus.rsp_valid_o && bus.rsp_ready_i) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 64'(bus.rsp_valid_o), 64'd0);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                check("rsp_rdata", 64'(bus.rsp_rdata_o), 64'(e[31:0]));
                check("rsp_err", 64'(bus.rsp_err_o), 64'(e[32]));
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_err, input bit push);
        bit ok = 0;
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = we;
        bus.req_addr_i  = addr;
        bus.req_wdata_i = wdata;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge CLK);
            if (bus.req_ready_o) begin
                if (push) sb.push_back({exp_err, exp_rd});
                @(posedge CLK);
                ok = 1;
            end
        end
        #1;
        bus.req_valid_i = 1'b0;
        check("accept", 64'(ok), 64'd1);
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge CLK);
            #1;
            if (bus.req_ready_o) ok = 1;
        end
        check("done_timeout", 64'(ok), 64'd1);
    endtask

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err);
        issue(we, addr, wdata, exp_rd, exp_err, 1'b1);
        wait_done();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, 64'(bus.req_ready_o), 64'd1);
        check({tag, "_valid"}, 64'(bus.rsp_valid_o), 64'd0);
        check({tag, "_we"}, 64'(bus.Write_Enable_o), 64'd0);
        check({tag, "_rdata"}, 64'(bus.rsp_rdata_o), 64'd0);
        check({tag, "_err"}, 64'(bus.rsp_err_o), 64'd0);
        check({tag, "_addr"}, 64'(bus.Address_o), 64'd0);
        check({tag, "_wdata"}, 64'(bus.Write_Data_o), 64'd0);
        check({tag, "_count"}, 64'(bus.txn_count_o), 64'd0);
    endtask

    int we_before;

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram[i] = 32'h5A00_0000 | 32'(i);
            rom[i] = 32'hC0DE_0000 | 32'(i);
        end
        bus.req_valid_i = 1'b0;
        bus.req_we_i    = 1'b0;
        bus.req_addr_i  = 32'h0;
        bus.req_wdata_i = 32'h0;
        bus.rsp_ready_i = 1'b1;

        repeat (3) @(posedge CLK);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;

        // store then load back through RAM
        we_before = we_cycles;
        txn(1'b1, 32'h1001_0008, 32'hDEAD_BEEF, 32'h0, 1'b0);
        check("store_we_pulse", 64'(we_cycles - we_before), 64'd1);
        txn(1'b0, 32'h1001_0008, 32'h0, 32'hDEAD_BEEF, 1'b0);
        check("count_t1", 64'(bus.txn_count_o), 64'd2);

        // ROM load with latency check
        issue(1'b0, 32'h0040_0004, 32'h0, 32'hC0DE_0001, 1'b0, 1'b1);
        check("lat_access_valid", 64'(bus.rsp_valid_o), 64'd0);
        check("lat_access_ready", 64'(bus.req_ready_o), 64'd0);
        @(posedge CLK);
        #1;
        check("lat_resp_valid", 64'(bus.rsp_valid_o), 64'd1);
        wait_done();
        check("count_t2", 64'(bus.txn_count_o), 64'd3);

        // store to ROM is rejected without a write
        we_before = we_cycles;
        txn(1'b1, 32'h0040_0000, 32'h0000_1234, 32'h0, 1'b1);
        check("rom_store_no_we", 64'(we_cycles - we_before), 64'd0);
        txn(1'b0, 32'h1001_0000, 32'h0, 32'h5A00_0000, 1'b0);
        check("count_t3", 64'(bus.txn_count_o), 64'd5);

        // address map boundaries
        txn(1'b0, 32'h1001_00FC, 32'h0, 32'h5A00_003F, 1'b0);
        txn(1'b0, 32'h1001_0100, 32'h0, 32'h0, 1'b1);
        txn(1'b0, 32'h0000_0000, 32'h0, 32'h0, 1'b1);
        txn(1'b0, 32'h0040_00FC, 32'h0, 32'hC0DE_003F, 1'b0);
        txn(1'b0, 32'h0040_0100, 32'h0, 32'h0, 1'b1);
        check("count_t4", 64'(bus.txn_count_o), 64'd10);

        // response back-pressure with a competing request on the inputs
        bus.rsp_ready_i = 1'b0;
        we_before = we_cycles;
        issue(1'b0, 32'h1001_0008, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
        bus.req_valid_i = 1'b1;
        bus.req_we_i    = 1'b1;
        bus.req_addr_i  = 32'h1001_0010;
        bus.req_wdata_i = 32'h5555_5555;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 64'(bus.rsp_valid_o), 64'd1);
            check("hold_rdata", 64'(bus.rsp_rdata_o), 64'hDEAD_BEEF);
            check("hold_ready", 64'(bus.req_ready_o), 64'd0);
            @(posedge CLK);
            #1;
        end
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        wait_done();
        check("count_t5", 64'(bus.txn_count_o), 64'd11);
        check("hold_no_we", 64'(we_cycles - we_before), 64'd0);

        // reset during the access cycle of a store
        issue(1'b1, 32'h1001_0020, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0);
        check("rst_we_in_access", 64'(bus.Write_Enable_o), 64'd1);
        rst_n = 1'b0;
        @(posedge CLK);
        #1;
        check_reset_vals("midrst");
        repeat (2) @(posedge CLK);
        #1;
        check("midrst_valid_late", 64'(bus.rsp_valid_o), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check("post_rst_valid", 64'(bus.rsp_valid_o), 64'd0);

`ifdef MISALIGN_CHECK_EN
        txn(1'b0, 32'h1001_0002, 32'h0, 32'h0, 1'b1);
`else
        txn(1'b0, 32'h1001_0002, 32'h0, 32'h5A00_0000, 1'b0);
`endif
        check("count_t6", 64'(bus.txn_count_o), 64'd1);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
